sprite_palette_ram: RTL
=======================

Name: sprite_palette_ram

Overview:
Writable, multi-bank colour palette for sprite and background rendering. It maps a pixel's palette index to RGB through a 2-cycle read pipeline, applies a global brightness fade driven by a frame-rate strobe, and flags the transparent index. It sits between the sprite ROM index output and the VGA colour mux. It replaces the per-sprite fixed combinational palettes, so palettes can be loaded and swapped at run time.

Parameters:
IDX_W, 6, palette index width; each bank holds 2**IDX_W entries.
NUM_PAL, 4, number of palette banks (power of 2, ≥2).
CH_W, 4, bits per colour channel; an entry is 3*CH_W bits, {R,G,B} with R in the MSBs.
FADE_DIV, 4, number of fade_step_i strobes per fade level step (≥1).
TRANSP_IDX, 0, index value reported as transparent.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_valid_i  in  1  read request qualifier
pal_sel_i  in  $clog2(NUM_PAL)  bank select for the read
index_i  in  IDX_W  palette index for the read
rgb_valid_o  out  1  output qualifier, pix_valid_i delayed 2 cycles
red_o  out  CH_W  faded red
green_o  out  CH_W  faded green
blue_o  out  CH_W  faded blue
transp_o  out  1  read index equalled TRANSP_IDX
wr_en_i  in  1  palette write strobe
wr_pal_i  in  $clog2(NUM_PAL)  write bank
wr_idx_i  in  IDX_W  write entry
wr_rgb_i  in  3*CH_W  write data {R,G,B}
fade_step_i  in  1  one-cycle strobe (vsync-derived)
fade_target_i  in  5  target brightness 0..16; values >16 are clamped to 16
fade_level_o  out  5  current brightness level
fade_busy_o  out  1  level != clamped target

Behaviour:
- Reset:
  - All outputs 0, except fade_level_o = 16 (full brightness).
  - Fade prescaler = 0; FSM in IDLE.
  - Palette RAM contents are not cleared; they are undefined until written.
- Storage: NUM_PAL*2**IDX_W entries, addressed as {bank, index}. Inferable as block RAM with a synchronous read.
- Read pipeline, request presented at cycle t:
  - t: RAM address = {pal_sel_i, index_i}. pix_valid_i and (index_i==TRANSP_IDX) are registered into stage 1.
  - t+1: RAM data is registered. Channels are scaled: c_out = (c * L) >> 4, where L = fade_level_o at t+1. The product is computed at CH_W+5 bits, then truncated to CH_W.
  - t+2: rgb_valid_o, red/green/blue_o and transp_o are presented.
  - Latency is exactly 2 cycles. Throughput is one request per cycle, with no stalls.
- pix_valid_i = 0: the pipeline still advances. Colour outputs are zero when rgb_valid_o = 0.
- transp_o is valid only with rgb_valid_o. RGB is still output for the transparent index.
- Level 16 passes colours unchanged; level 0 gives black.
- Write: wr_en_i at cycle t updates the entry at the end of t. A read issued at t+1 or later returns the new data. Writes and reads may target different banks in the same cycle.
- Fade FSM:
  - States: IDLE and FADING.
  - IDLE → FADING when fade_level_o != clamped target (evaluated every cycle).
  - In FADING, each fade_step_i strobe increments the prescaler. When the prescaler reaches FADE_DIV-1 on a strobe, it resets to 0 and the level moves by 1 toward the target.
  - FADING → IDLE when level == target. The prescaler clears on entry to IDLE.
  - A target change during FADING takes effect immediately: the direction is re-evaluated and the prescaler is kept.
  - A target equal to the current level while FADING → IDLE on the next cycle.
  - fade_busy_o = (state == FADING).
- Reset asserted mid-frame or mid-fade: pipeline outputs go to 0 immediately, level returns to 16, and there is no partial write.

Optional Feature:
Macro: SPRITE_PAL_RD_BYPASS_EN
- With the macro: a read at cycle t to the same {bank, index} as a write at t returns wr_rgb_i. The bypass data is forwarded into stage 1.
- Without the macro: such a read returns the old entry contents (read-first). RAM inference then needs no forwarding mux.

Test Plan:
1. Reset, then write bank 1 idx 5 = 12'hE4B; read bank 1 idx 5 at cycle t → rgb_valid_o=1, R/G/B = E/4/B at t+2; transp_o=0.
2. Back-to-back reads every cycle of bank 0 idx 0..63 after loading entry i = {i[3:0],~i[3:0],i[3:0]} → each result appears 2 cycles later, in order, with no gaps. transp_o=1 only for idx 0 (TRANSP_IDX).
3. Entry 12'hFFF at fade_target_i=8, FADE_DIV=4 → fade_busy_o=1. The level drops 16→15 after 4 strobes and reaches 8 after 32 strobes, then busy=0. Read at level 8 → 7/7/7.
4. During a fade 16→0 with level=10, change the target to 14 → direction reverses; the level reaches 14 after 4 more level steps; busy=0.
5. Same-cycle write of 12'h123 and read of bank 2 idx 9 (old 12'hABC) → result ABC without the macro, 123 with SPRITE_PAL_RD_BYPASS_EN. A read at the next cycle → 123 in both builds.
6. Assert reset_n=0 during streaming reads at level 5 → all outputs 0 asynchronously and fade_level_o=16. Previously written entries still read back correctly after release.

Source files
------------

// File: rtl/sprite_palette_ram.sv
// sprite_palette_ram: multi-bank palette RAM with a 2-cycle read pipeline, brightness fade and transparency flag.
// Define SPRITE_PAL_RD_BYPASS_EN to forward same-cycle write data to a colliding read.
module sprite_palette_ram #(
  parameter int IDX_W      = 6,
  parameter int NUM_PAL    = 4,
  parameter int CH_W       = 4,
  parameter int FADE_DIV   = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pix_valid_i,
  input  logic [$clog2(NUM_PAL)-1:0] pal_sel_i,
  input  logic [IDX_W-1:0]           index_i,
  output logic                       rgb_valid_o,
  output logic [CH_W-1:0]            red_o,
  output logic [CH_W-1:0]            green_o,
  output logic [CH_W-1:0]            blue_o,
  output logic                       transp_o,
  input  logic                       wr_en_i,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal_i,
  input  logic [IDX_W-1:0]           wr_idx_i,
  input  logic [3*CH_W-1:0]          wr_rgb_i,
  input  logic                       fade_step_i,
  input  logic [4:0]                 fade_target_i,
  output logic [4:0]                 fade_level_o,
  output logic                       fade_busy_o
);
  localparam int AW  = $clog2(NUM_PAL) + IDX_W;
  localparam int DW  = 3 * CH_W;
  localparam int PW  = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  localparam int PRW = CH_W + 5;

  typedef enum logic {IDLE, FADING} st_t;

  logic [DW-1:0]   mem_q [2**AW];
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [DW-1:0]   rd_d, rd_q;
  logic            v1_q, t1_q, v2_q, t2_q;
  logic [CH_W-1:0] r_q, g_q, b_q;
  st_t             st_q, st_d;
  logic [4:0]      level_q, level_d, tgt;
  logic [PW-1:0]   pre_q, pre_d;

  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [4:0] l);
    logic [PRW-1:0] p;
    p = PRW'(c) * PRW'(l);
    return CH_W'(p >> 4);
  endfunction

  assign rd_addr = {pal_sel_i, index_i};
  assign wr_addr = {wr_pal_i, wr_idx_i};

`ifdef SPRITE_PAL_RD_BYPASS_EN
  assign rd_d = (wr_en_i && wr_addr == rd_addr) ? wr_rgb_i : mem_q[rd_addr];
`else
  assign rd_d = mem_q[rd_addr];
`endif

  // Reset gates the write so an asynchronous reset never corrupts an entry.
  always_ff @(posedge clk) begin
    if (wr_en_i && reset_n) mem_q[wr_addr] <= wr_rgb_i;
    rd_q <= rd_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      t1_q <= 1'b0;
      v2_q <= 1'b0;
      t2_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      v1_q <= pix_valid_i;
      t1_q <= index_i == IDX_W'(TRANSP_IDX);
      v2_q <= v1_q;
      t2_q <= v1_q & t1_q;
      r_q  <= v1_q ? scale(rd_q[DW-1 -: CH_W], level_q) : '0;
      g_q  <= v1_q ? scale(rd_q[2*CH_W-1 -: CH_W], level_q) : '0;
      b_q  <= v1_q ? scale(rd_q[CH_W-1:0], level_q) : '0;
    end
  end

  assign tgt = fade_target_i > 5'd16 ? 5'd16 : fade_target_i;

  always_comb begin
    st_d    = st_q;
    level_d = level_q;
    pre_d   = pre_q;
    if (st_q == IDLE) begin
      pre_d = '0;
      if (level_q != tgt) st_d = FADING;
    end else if (level_q == tgt) begin
      st_d  = IDLE;
      pre_d = '0;
    end else if (fade_step_i) begin
      pre_d   = pre_q == PW'(FADE_DIV - 1) ? '0 : pre_q + PW'(1);
      level_d = pre_q != PW'(FADE_DIV - 1) ? level_q : level_q < tgt ? level_q + 5'd1 : level_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= IDLE;
      level_q <= 5'd16;
      pre_q   <= '0;
    end else begin
      st_q    <= st_d;
      level_q <= level_d;
      pre_q   <= pre_d;
    end
  end

  assign rgb_valid_o  = v2_q;
  assign transp_o     = t2_q;
  assign red_o        = r_q;
  assign green_o      = g_q;
  assign blue_o       = b_q;
  assign fade_level_o = level_q;
  assign fade_busy_o  = st_q == FADING;
endmodule
